// File: rtl/alu_cmd_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_cmd_sequencer_if
//   Command / response channel bundle between a host command source and the
//   ALU command sequencer.
//
//   Command channel (valid/ready): cmd_valid, cmd_ready, cmd_op, cmd_rd,
//                                  cmd_rs1, cmd_rs2, cmd_imm
//   Response channel (valid/ready): rsp_valid, rsp_ready, rsp_data,
//                                   rsp_flags {Z,C,V,SLT}, rsp_err
//
//   master : host side (issues commands, consumes responses)
//   slave  : sequencer side (accepts commands, produces responses)
// ----------------------------------------------------------------------------
interface alu_cmd_sequencer_if #(
    parameter int unsigned DW = 4,
    parameter int unsigned AW = 2
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs1;
    logic [AW-1:0] cmd_rs2;
    logic [DW-1:0] cmd_imm;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [3:0]    rsp_flags;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_flags, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_flags, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// alu_cmd_sequencer
//   Initiator side of a DW-bit combinational ALU. Accepts one command per
//   handshake, reads operands from a small register file, drives the ALU
//   with registered A/B/OpCode, captures Result and flags, writes the result
//   back and returns a response.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   bus             command/response channels (slave modport)
//   alu_a, alu_b    registered ALU operands
//   alu_opcode      registered ALU opcode
//   alu_result      ALU result
//   alu_slt/zero/carry/ovf  ALU flags
//   flags_q         sticky last-good {Z,C,V,SLT}
//
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT,
//          110 LOADI (rd <= imm), 111 reserved (error response)
// Throughput: one command per three cycles (IDLE -> EXEC -> RESP).
// ----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int unsigned DW    = 4,
    parameter int unsigned NREGS = 4,
    parameter int unsigned AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_cmd_sequencer_if.slave   bus,
    output logic [DW-1:0]        alu_a,
    output logic [DW-1:0]        alu_b,
    output logic [2:0]           alu_opcode,
    input  logic [DW-1:0]        alu_result,
    input  logic                 alu_slt,
    input  logic                 alu_zero,
    input  logic                 alu_carry,
    input  logic                 alu_ovf,
    output logic [3:0]           flags_q
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_SLT   = 3'b101,
        OP_LOADI = 3'b110,
        OP_RSVD  = 3'b111
    } op_e;

    state_e        state;
    op_e           op_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] rf [NREGS];

    logic [3:0]    alu_flags;

    assign alu_flags = {alu_zero, alu_carry, alu_ovf, alu_slt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            op_q          <= OP_ADD;
            rd_q          <= '0;
            imm_q         <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
            alu_a         <= '0;
            alu_b         <= '0;
            alu_opcode    <= '0;
            flags_q       <= '0;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_flags <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        op_q          <= op_e'(bus.cmd_op);
                        rd_q          <= bus.cmd_rd;
                        imm_q         <= bus.cmd_imm;
                        bus.cmd_ready <= 1'b0;
                        state         <= ST_EXEC;
                        // Operands are snapshotted here, so rd == rs1/rs2
                        // reads the old value. LOADI/reserved leave the
                        // ALU inputs untouched.
                        if (bus.cmd_op <= OP_SLT) begin
                            alu_a      <= rf[bus.cmd_rs1];
                            alu_b      <= rf[bus.cmd_rs2];
                            alu_opcode <= bus.cmd_op;
                        end
                    end
                end

                ST_EXEC: begin
                    bus.rsp_valid <= 1'b1;
                    state         <= ST_RESP;
                    case (op_q)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
                            rf[rd_q]      <= alu_result;
                            bus.rsp_data  <= alu_result;
                            bus.rsp_flags <= alu_flags;
                            bus.rsp_err   <= 1'b0;
                            flags_q       <= alu_flags;
                        end
                        OP_LOADI: begin
                            rf[rd_q]      <= imm_q;
                            bus.rsp_data  <= imm_q;
                            bus.rsp_flags <= {(imm_q == '0), 3'b000};
                            bus.rsp_err   <= 1'b0;
                            flags_q       <= {(imm_q == '0), 3'b000};
                        end
                        default: begin
                            // Reserved opcode: error response only, no
                            // register or sticky-flag side effects.
                            bus.rsp_data  <= '0;
                            bus.rsp_flags <= '0;
                            bus.rsp_err   <= 1'b1;
                        end
                    endcase
                end

                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end

                default: begin
                    bus.rsp_valid <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
